muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the core's execute stage. It is the multi-cycle companion to the single-cycle ALU, generalised in operand width and radix (bits retired per cycle). It takes operands over a valid/ready handshake, computes over several cycles, and holds the result until the consumer takes it.

## Interface
- XLEN, 32: operand/result width; even, ≥ 8.
- BITS_PER_CYCLE, 1: bits retired per iteration; 1, 2 or 4, must divide XLEN.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- flush  in  1  abandon any operation in flight (branch redirect).
- in_valid  in  1  operands/op valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  XLEN  rs1 operand (multiplicand/dividend).
- b  in  XLEN  rs2 operand (multiplier/divisor).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  result.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: in_ready=1. On in_valid: latch op, take |a|, |b| per signedness (MULH/DIV/REM: both signed; MULHSU: a signed only; others unsigned), record result sign, clear iteration counter.
- Special cases detected at accept, go straight to DONE: divisor zero -> DIV/DIVU quotient all-ones, REM/REMU result = a; signed overflow (a = most-negative, b = −1, DIV/REM) -> quotient = a, remainder 0.
- CALC: multiply = shift-add of BITS_PER_CYCLE multiplier bits per cycle into a 2·XLEN product; divide = restoring, BITS_PER_CYCLE quotient bits per cycle. Counter runs 0..XLEN/BITS_PER_CYCLE−1, then FIXUP.
- FIXUP: two's-complement negate if sign recorded (quotient sign = sa^sb; remainder sign = sa; product sign = sa^sb, MULHSU uses sa). Select low half (MUL), high half (MULH*), quotient or remainder. Go to DONE.
- DONE: out_valid=1, result stable; on out_ready go to IDLE. No new accept in the same cycle (in_ready only in IDLE).
- flush: any state -> IDLE next edge, out_valid dropped, result not delivered; flush with in_valid in IDLE blocks the accept.
- All arithmetic unsigned internally; the most-negative operand's magnitude is exactly representable in XLEN bits unsigned.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, counter 0.
- Accept on edge E (in_valid & in_ready): normal ops have out_valid high after edge E + XLEN/BITS_PER_CYCLE + 2 (XLEN=32, BPC=1: 34 cycles). Special cases: out_valid high after edge E+1.
- Result and out_valid held indefinitely while out_ready=0; dropped the cycle after the out_ready handshake edge; in_ready rises in that same cycle.
- Back-to-back: minimum one IDLE cycle between out handshake and next accept.
- rst and flush both mid-CALC: next edge IDLE, no partial result visible; rst has priority over everything.
- in_valid ignored outside IDLE; operands need not stay stable after accept.

## Structure
- Package muldiv_pkg: op encodings (localparams matching funct3), state enum, special-case helper constants (most-negative value as function of XLEN).
- One sub-module, muldiv_step: combinational single iteration (BITS_PER_CYCLE-bit shift-add or restoring-subtract step), instantiated once; FSM, sign handling and handshake in muldiv_unit.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), out_ready=1 -> result 0xFFFFFFEB, out_valid exactly 34 cycles after accept (XLEN 32, BPC 1); repeat with BPC 4 -> 10 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD, REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/−1 -> 0x80000000, REM -> 0; each out_valid one cycle after accept.
- out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready 0; release -> in_ready 1 next cycle.
- rst asserted at CALC iteration 10, then flush at iteration 10 of a new op -> IDLE next edge, out_valid never rises, subsequent MUL 3×4 returns 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Most-negative two's-complement value of an xlen-bit word (callers truncate).
  function automatic logic [63:0] most_neg(input int unsigned xlen);
    return 64'd1 << (xlen - 32'd1);
  endfunction

  function automatic logic signed_a(input logic [2:0] op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic signed_b(input logic [2:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result handshake bundle between the execute stage and muldiv_unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result);
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: BITS_PER_CYCLE-bit shift-add multiply or
// BITS_PER_CYCLE restoring-divide steps on the {hi, lo} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  localparam int BPC = BITS_PER_CYCLE;

  logic [XLEN+BPC-1:0] mul_pp_d;
  logic [XLEN+BPC-1:0] mul_hi_d;
  logic [2*XLEN-1:0]   mul_acc_d;
  logic [XLEN:0]       rem_ext_d;
  logic [XLEN-1:0]     div_rem_d;
  logic [XLEN-1:0]     div_quo_d;

  // Multiply: add (low multiplier digit x multiplicand) into the high half, then shift right.
  always_comb begin
    mul_pp_d  = {{BPC{1'b0}}, opnd_i} * {{XLEN{1'b0}}, acc_i[BPC-1:0]};
    mul_hi_d  = {{BPC{1'b0}}, acc_i[2*XLEN-1:XLEN]} + mul_pp_d;
    mul_acc_d = {mul_hi_d, acc_i[XLEN-1:BPC]};
  end

  // Divide: hi holds the partial remainder, lo shifts the dividend out and quotient bits in.
  always_comb begin
    div_rem_d = acc_i[2*XLEN-1:XLEN];
    div_quo_d = acc_i[XLEN-1:0];
    rem_ext_d = {(XLEN+1){1'b0}};
    for (int i = 0; i < BPC; i++) begin
      rem_ext_d = {div_rem_d, div_quo_d[XLEN-1]};
      if (rem_ext_d >= {1'b0, opnd_i}) begin
        rem_ext_d = rem_ext_d - {1'b0, opnd_i};
        div_quo_d = {div_quo_d[XLEN-2:0], 1'b1};
      end else begin
        div_quo_d = {div_quo_d[XLEN-2:0], 1'b0};
      end
      div_rem_d = rem_ext_d[XLEN-1:0];
    end
  end

  // Select the datapath for the operation in flight.
  always_comb begin
    if (is_div_i) begin
      acc_o = {div_rem_d, div_quo_d};
    end else begin
      acc_o = mul_acc_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude arithmetic over
// XLEN/BITS_PER_CYCLE iterations, sign fix-up, and a registered result handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  muldiv_if.slave bus
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  MOST_NEG = XLEN'(most_neg(XLEN));

  state_t            state_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   result_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              sa_d, sb_d, neg_d, special_d;
  logic [XLEN-1:0]   mag_a_d, mag_b_d, opnd_init_d, special_res_d;
  logic [2*XLEN-1:0] acc_init_d, acc_step_d, prod_fix_d;
  logic [XLEN-1:0]   quo_fix_d, rem_fix_d, result_fix_d;

  muldiv_step #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step_d)
  );

  // Accept-time decode: operand magnitudes, result sign and special cases.
  always_comb begin
    sa_d    = signed_a(bus.op) & bus.a[XLEN-1];
    sb_d    = signed_b(bus.op) & bus.b[XLEN-1];
    mag_a_d = sa_d ? (~bus.a + ONE) : bus.a;
    mag_b_d = sb_d ? (~bus.b + ONE) : bus.b;
    if (bus.op[2]) begin
      neg_d       = bus.op[1] ? sa_d : (sa_d ^ sb_d);
      acc_init_d  = {ZERO, mag_a_d};
      opnd_init_d = mag_b_d;
    end else begin
      neg_d       = sa_d ^ sb_d;
      acc_init_d  = {ZERO, mag_b_d};
      opnd_init_d = mag_a_d;
    end
    if (bus.op[2] && (bus.b == ZERO)) begin
      special_d     = 1'b1;
      special_res_d = bus.op[1] ? bus.a : ONES;
    end else if (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.a == MOST_NEG) && (bus.b == ONES)) begin
      special_d     = 1'b1;
      special_res_d = bus.op[1] ? ZERO : bus.a;
    end else begin
      special_d     = 1'b0;
      special_res_d = ZERO;
    end
  end

  // Fix-up: apply the recorded sign and pick the requested half/quotient/remainder.
  always_comb begin
    prod_fix_d = neg_q ? (~acc_q + {ZERO, ONE}) : acc_q;
    quo_fix_d  = neg_q ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
    rem_fix_d  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + ONE) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        result_fix_d = prod_fix_d[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_fix_d = prod_fix_d[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result_fix_d = quo_fix_d;
      OP_REM, OP_REMU:               result_fix_d = rem_fix_d;
      default:                       result_fix_d = ZERO;
    endcase
  end

  // Control FSM; out_valid rises one cycle after entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      neg_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      acc_q       <= {(2*XLEN){1'b0}};
      opnd_q      <= ZERO;
      result_q    <= ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            neg_q      <= neg_d;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= acc_init_d;
            opnd_q     <= opnd_init_d;
            in_ready_q <= 1'b0;
            if (special_d) begin
              result_q <= special_res_d;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_step_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= S_FIXUP;
          end else begin
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_FIXUP: begin
          result_q <= result_fix_d;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: one DUT at 1 bit/cycle and
// one at 4 bits/cycle, with hand-computed results and latencies.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  muldiv_if #(.XLEN(32)) if1 ();
  muldiv_if #(.XLEN(32)) if4 ();

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut  (.clk(clk), .rst(rst), .flush(flush), .bus(if1));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .flush(flush), .bus(if4));

  always #5 clk = ~clk;

  // Present an op for one edge (caller is #1 after an edge with the DUT idle).
  task automatic launch(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      if4.in_valid = 1'b1; if4.op = op; if4.a = a; if4.b = b;
    end else begin
      if1.in_valid = 1'b1; if1.op = op; if1.a = a; if1.b = b;
    end
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    if4.in_valid = 1'b0;
    if1.a = 32'h0; if1.b = 32'h0; if4.a = 32'h0; if4.b = 32'h0;
  endtask

  // Count edges after accept until out_valid is seen (bounded).
  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    while (((sel ? if4.out_valid : if1.out_valid) !== 1'b1) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    if1.out_ready = 1'b1;
    if4.out_ready = 1'b1;
    launch(sel, op, a, b);
    wait_valid(sel, lat);
    res = sel ? if4.result : if1.result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({if1.in_ready, if1.out_valid, if1.result} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL reset_bpc1: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0",
               if1.in_ready, if1.out_valid, if1.result);
    else pass_cnt++;
    total_cnt++;
    if ({if4.in_ready, if4.out_valid, if4.result} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL reset_bpc4: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0",
               if4.in_ready, if4.out_valid, if4.result);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat;
    do_op(1'b0, OP_MUL, 32'd7, 32'hFFFF_FFFD, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFEB) $display("FAIL mul_bpc1: got %h expected ffffffeb", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 34) $display("FAIL mul_lat_bpc1: got %0d expected 34", lat); else pass_cnt++;
    do_op(1'b1, OP_MUL, 32'd7, 32'hFFFF_FFFD, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFEB) $display("FAIL mul_bpc4: got %h expected ffffffeb", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 10) $display("FAIL mul_lat_bpc4: got %0d expected 10", lat); else pass_cnt++;
  endtask

  task automatic test_mulh();
    logic [31:0] res;
    int lat;
    do_op(1'b0, OP_MULH, 32'h8000_0000, 32'h8000_0000, res, lat);
    total_cnt++;
    if (res !== 32'h4000_0000) $display("FAIL mulh: got %h expected 40000000", res); else pass_cnt++;
    do_op(1'b0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFFE) $display("FAIL mulhu: got %h expected fffffffe", res); else pass_cnt++;
    do_op(1'b0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL mulhsu: got %h expected ffffffff", res); else pass_cnt++;
    do_op(1'b1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL mulhsu_bpc4: got %h expected ffffffff", res); else pass_cnt++;
  endtask

  task automatic test_div();
    logic [31:0] res;
    int lat;
    do_op(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFFD) $display("FAIL div: got %h expected fffffffd", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 34) $display("FAIL div_lat: got %0d expected 34", lat); else pass_cnt++;
    do_op(1'b0, OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL rem: got %h expected ffffffff", res); else pass_cnt++;
    do_op(1'b0, OP_DIVU, 32'd100, 32'd7, res, lat);
    total_cnt++;
    if (res !== 32'd14) $display("FAIL divu: got %h expected 0000000e", res); else pass_cnt++;
    do_op(1'b0, OP_REMU, 32'd100, 32'd7, res, lat);
    total_cnt++;
    if (res !== 32'd2) $display("FAIL remu: got %h expected 00000002", res); else pass_cnt++;
    do_op(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    total_cnt++;
    if (res !== 32'hFFFF_FFFD) $display("FAIL div_bpc4: got %h expected fffffffd", res); else pass_cnt++;
    do_op(1'b1, OP_REMU, 32'd100, 32'd7, res, lat);
    total_cnt++;
    if (res !== 32'd2) $display("FAIL remu_bpc4: got %h expected 00000002", res); else pass_cnt++;
  endtask

  task automatic test_special();
    logic [31:0] res;
    int lat;
    do_op(1'b0, OP_DIVU, 32'd5, 32'd0, res, lat);
    total_cnt++;
    if ({res, lat} !== {32'hFFFF_FFFF, 32'd1})
      $display("FAIL divu_by0: got res=%h lat=%0d expected ffffffff lat=1", res, lat);
    else pass_cnt++;
    do_op(1'b0, OP_REM, 32'd5, 32'd0, res, lat);
    total_cnt++;
    if ({res, lat} !== {32'd5, 32'd1})
      $display("FAIL rem_by0: got res=%h lat=%0d expected 00000005 lat=1", res, lat);
    else pass_cnt++;
    do_op(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    total_cnt++;
    if ({res, lat} !== {32'h8000_0000, 32'd1})
      $display("FAIL div_ovf: got res=%h lat=%0d expected 80000000 lat=1", res, lat);
    else pass_cnt++;
    do_op(1'b0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    total_cnt++;
    if ({res, lat} !== {32'h0, 32'd1})
      $display("FAIL rem_ovf: got res=%h lat=%0d expected 00000000 lat=1", res, lat);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    int lat;
    if1.out_ready = 1'b0;
    launch(1'b0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(1'b0, lat);
    total_cnt++;
    if (lat !== 34) $display("FAIL hold_lat: got %0d expected 34", lat); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({if1.out_valid, if1.in_ready, if1.result} !== {1'b1, 1'b0, 32'hFFFF_FFFE})
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h expected vld=1 rdy=0 res=fffffffe",
                 i, if1.out_valid, if1.in_ready, if1.result);
      else pass_cnt++;
    end
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({if1.out_valid, if1.in_ready} !== 2'b01)
      $display("FAIL hold_release: got vld=%b rdy=%b expected vld=0 rdy=1", if1.out_valid, if1.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int lat;
    bit seen;
    launch(1'b0, OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total_cnt++;
    if ({if1.in_ready, if1.out_valid, if1.result} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL rst_mid_calc: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0",
               if1.in_ready, if1.out_valid, if1.result);
    else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (if1.out_valid) seen = 1'b1; end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rst_no_result: got out_valid seen=%b expected 0", seen); else pass_cnt++;

    launch(1'b0, OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    total_cnt++;
    if ({if1.in_ready, if1.out_valid} !== 2'b10)
      $display("FAIL flush_mid_calc: got rdy=%b vld=%b expected rdy=1 vld=0", if1.in_ready, if1.out_valid);
    else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (if1.out_valid) seen = 1'b1; end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL flush_no_result: got out_valid seen=%b expected 0", seen); else pass_cnt++;

    if1.in_valid = 1'b1; if1.op = OP_MUL; if1.a = 32'd9; if1.b = 32'd9; flush = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0; flush = 1'b0;
    total_cnt++;
    if (if1.in_ready !== 1'b1) $display("FAIL flush_blocks_accept: got in_ready=%b expected 1", if1.in_ready);
    else pass_cnt++;

    do_op(1'b0, OP_MUL, 32'd3, 32'd4, res, lat);
    total_cnt++;
    if ({res, lat} !== {32'd12, 32'd34})
      $display("FAIL mul_after_abort: got res=%h lat=%0d expected 0000000c lat=34", res, lat);
    else pass_cnt++;
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.op = 3'd0; if1.a = 32'h0; if1.b = 32'h0; if1.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.op = 3'd0; if4.a = 32'h0; if4.b = 32'h0; if4.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_hold();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
